fb_write_scheduler: RTL



---
 rtl/fb_write_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fb_write_scheduler.sv
// Clears the colour and depth buffers at frame start, then applies depth-tested pixel writes.
// Accepts one request every 2 cycles: ACCEPT issues the depth read and TEST writes on a hit.
module fb_write_scheduler #(
  parameter int FB_WIDTH       = 160,
  parameter int FB_HEIGHT      = 120,
  parameter int FB_ADDRW       = 15,
  parameter int FB_DATAW       = 4,
  parameter int DB_DATAW       = 12,
  parameter int FB_CLEAR_VALUE = 0,
  parameter int DB_CLEAR_VALUE = 4095
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  output logic                raster_start,
  input  logic                raster_done,
  input  logic                rq_valid,
  output logic                rq_ready,
  input  logic [FB_ADDRW-1:0] rq_addr,
  input  logic [FB_DATAW-1:0] rq_colr,
  input  logic [DB_DATAW-1:0] rq_depth,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr,
  output logic [FB_DATAW-1:0] fb_data,
  output logic                db_we,
  output logic [FB_ADDRW-1:0] db_addr,
  output logic [DB_DATAW-1:0] db_data,
  output logic [FB_ADDRW-1:0] db_addr_read,
  input  logic [DB_DATAW-1:0] db_data_read,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun,
  output logic [15:0]         px_written
);
  localparam int NPIX = FB_WIDTH * FB_HEIGHT;
  localparam logic [FB_ADDRW-1:0] LAST_ADDR = FB_ADDRW'(NPIX - 1);
  localparam logic [FB_DATAW-1:0] FB_CLR    = FB_DATAW'(FB_CLEAR_VALUE);
  localparam logic [DB_DATAW-1:0] DB_CLR    = DB_DATAW'(DB_CLEAR_VALUE);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCEPT, TEST, FINISH} state_t;

  state_t              state;
  logic [FB_ADDRW-1:0] wr_addr_q, rd_addr_q, lat_addr;
  logic [FB_DATAW-1:0] fb_data_q, lat_colr;
  logic [DB_DATAW-1:0] db_data_q, lat_depth;
  logic                we_q, done_pend, hit;

  // The TEST-cycle write bypasses the registers so the strobe lands one cycle after acceptance.
  assign hit          = (state == TEST) && (lat_addr <= LAST_ADDR) && (lat_depth < db_data_read);
  assign rq_ready     = (state == ACCEPT);
  assign db_addr_read = (state == ACCEPT) ? rq_addr : rd_addr_q;
  assign overrun      = frame_start && busy;
  assign fb_we        = we_q | hit;
  assign db_we        = we_q | hit;
  assign fb_addr      = hit ? lat_addr : wr_addr_q;
  assign db_addr      = hit ? lat_addr : wr_addr_q;
  assign fb_data      = hit ? lat_colr : fb_data_q;
  assign db_data      = hit ? lat_depth : db_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      lat_addr     <= '0;
      lat_colr     <= '0;
      lat_depth    <= '0;
      fb_data_q    <= '0;
      db_data_q    <= '0;
      we_q         <= 1'b0;
      done_pend    <= 1'b0;
      busy         <= 1'b0;
      raster_start <= 1'b0;
      frame_done   <= 1'b0;
      px_written   <= '0;
    end else begin
      raster_start <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= CLEAR;
            busy       <= 1'b1;
            we_q       <= 1'b1;
            wr_addr_q  <= '0;
            fb_data_q  <= FB_CLR;
            db_data_q  <= DB_CLR;
            px_written <= '0;
          end
        end
        CLEAR: begin
          // The write address register doubles as the clear counter.
          if (wr_addr_q == LAST_ADDR) begin
            state        <= ACCEPT;
            we_q         <= 1'b0;
            raster_start <= 1'b1;
          end else begin
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end
        ACCEPT: begin
          if (rq_valid) begin
            lat_addr  <= rq_addr;
            lat_colr  <= rq_colr;
            lat_depth <= rq_depth;
            rd_addr_q <= rq_addr;
            done_pend <= raster_done;
            state     <= TEST;
          end else if (raster_done) begin
            state      <= FINISH;
            frame_done <= 1'b1;
          end
        end
        TEST: begin
          if (hit) begin
            wr_addr_q <= lat_addr;
            fb_data_q <= lat_colr;
            db_data_q <= lat_depth;
            if (px_written != 16'hFFFF) px_written <= px_written + 1'b1;
          end
          if (done_pend || raster_done) begin
            state      <= FINISH;
            frame_done <= 1'b1;
          end else begin
            state <= ACCEPT;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
